// File: rtl/c3lib_rst_seq_ctrl.sv
// Purpose : releases NUM_STG active-low resets one after another. Each stage
//           gets a DLY_CYC pre-release delay, then must acknowledge within
//           TMO_CYC cycles via its stat_n bit before the next stage starts.
// Latency : stage 0 is released DLY_CYC cycles after seq_en is first sampled;
//           with immediate acks, seq_done rises NUM_STG*(DLY_CYC+1) cycles
//           after that sampling edge.
// Backpressure: none. A missing ack or a released stage falling back into
//           reset drops every stage and raises seq_err; seq_en=0 aborts at once.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   seq_en     level request: 1 = run the sequence, 0 = hold all stages in reset
//   stat_n     per-stage status, already synchronized (0 = stage out of reset)
//   rst_out_n  per-stage active-low reset, registered
//   seq_busy   registered, 1 while a stage is in its delay or ack window
//   seq_done   registered, 1 once every stage is released and acknowledged
//   seq_err    registered, 1 after a timeout or a lost ack; held until seq_en=0
module c3lib_rst_seq_ctrl #(
  parameter int NUM_STG = 4,
  parameter int DLY_CYC = 8,
  parameter int TMO_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               seq_en,
  input  logic [NUM_STG-1:0] stat_n,
  output logic [NUM_STG-1:0] rst_out_n,
  output logic               seq_busy,
  output logic               seq_done,
  output logic               seq_err
);

  // One counter serves both the delay and the ack timeout, so it must hold
  // the larger of the two terminal values.
  localparam int MAX_CYC = (DLY_CYC > TMO_CYC) ? DLY_CYC : TMO_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = (NUM_STG > 1) ? $clog2(NUM_STG) : 1;

  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DLY_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STG - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DLY,
    ST_ACK,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      cnt       <= '0;
      rst_out_n <= '0;
      seq_busy  <= 1'b0;
      seq_done  <= 1'b0;
      seq_err   <= 1'b0;
    end else if (state != ST_IDLE && !seq_en) begin
      // Abort outranks every other transition, including a coincident ack.
      state     <= ST_IDLE;
      idx       <= '0;
      cnt       <= '0;
      rst_out_n <= '0;
      seq_busy  <= 1'b0;
      seq_done  <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (seq_en) begin
            state    <= ST_DLY;
            idx      <= '0;
            cnt      <= '0;
            seq_busy <= 1'b1;
          end
        end

        ST_DLY: begin
          if (cnt == DLY_LAST) begin
            rst_out_n[idx] <= 1'b1;
            cnt            <= '0;
            state          <= ST_ACK;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_ACK: begin
          // Only the stage just released is watched. An ack on the timeout
          // edge still counts as an ack.
          if (!stat_n[idx]) begin
            cnt <= '0;
            if (idx == IDX_LAST) begin
              state    <= ST_DONE;
              seq_busy <= 1'b0;
              seq_done <= 1'b1;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= ST_DLY;
            end
          end else if (cnt == TMO_LAST) begin
            state     <= ST_ERR;
            rst_out_n <= '0;
            cnt       <= '0;
            seq_busy  <= 1'b0;
            seq_err   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_DONE: begin
          // Any stage falling back into reset invalidates the whole sequence.
          if (|stat_n) begin
            state     <= ST_ERR;
            rst_out_n <= '0;
            seq_done  <= 1'b0;
            seq_err   <= 1'b1;
          end
        end

        ST_ERR: begin
          // Held until seq_en drops (handled by the abort branch).
        end

        default: begin
          state     <= ST_IDLE;
          idx       <= '0;
          cnt       <= '0;
          rst_out_n <= '0;
          seq_busy  <= 1'b0;
          seq_done  <= 1'b0;
          seq_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/c3lib_rst_seq_ctrl.md
C3LIB_RST_SEQ_CTRL -- requirements
Module: c3lib_rst_seq_ctrl

Interface
REQ-001 Parameter NUM_STG, default 4, SHALL be the number of sequenced reset stages (legal 1..16).
REQ-002 Parameter DLY_CYC, default 8, SHALL be the pre-release delay per stage in clk cycles (legal >=1).
REQ-003 Parameter TMO_CYC, default 255, SHALL be the per-stage acknowledge timeout in clk cycles (legal >=1).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 seq_en  input  1  SHALL be the level request: 1 = run sequence, 0 = hold all stages in reset.
REQ-007 stat_n  input  NUM_STG  SHALL be per-stage status, already synchronized into clk upstream by 2-stage set synchronizers (idle value 1); 0 = stage confirmed out of reset.
REQ-008 rst_out_n  output  NUM_STG  SHALL be the per-stage active-low reset, registered.
REQ-009 seq_busy  output  1  SHALL be 1 while in DLY or ACK states, registered.
REQ-010 seq_done  output  1  SHALL be 1 in DONE state, registered.
REQ-011 seq_err  output  1  SHALL be 1 in ERR state, registered.

Function
REQ-012 FSM states SHALL be IDLE, DLY, ACK, DONE, ERR; a stage index idx (0..NUM_STG-1) and one shared counter cnt, width clog2(max(DLY_CYC,TMO_CYC)+1).
REQ-013 IDLE: seq_en=1 sampled SHALL go to DLY, idx=0, cnt=0; otherwise remain IDLE.
REQ-014 DLY: cnt SHALL increment each cycle; at edge with cnt==DLY_CYC-1 set rst_out_n[idx]=1, cnt=0, go ACK.
REQ-015 Latency: rst_out_n[0] SHALL rise exactly DLY_CYC cycles after the edge first sampling seq_en=1.
REQ-016 ACK: stat_n[idx]==0 sampled SHALL advance: idx==NUM_STG-1 -> DONE, else idx+1, cnt=0 -> DLY.
REQ-017 ACK: stat_n[idx]==1 at edge with cnt==TMO_CYC-1 SHALL go ERR; otherwise cnt increments.
REQ-018 Ack and timeout on the same edge SHALL resolve as ack (no ERR).
REQ-019 Only stat_n[idx] SHALL be evaluated in ACK; other bits ignored.
REQ-020 Released stages SHALL stay released (rst_out_n bits monotonic 0->1) until seq_en=0 or ERR.
REQ-021 DONE: any stat_n bit returning to 1 SHALL go ERR.
REQ-022 ERR: all rst_out_n SHALL be 0 on the edge entering ERR; ERR held until seq_en=0.
REQ-023 seq_en=0 sampled in any non-IDLE state SHALL, on that edge, set all rst_out_n=0, idx=0, cnt=0, clear seq_done/seq_err/seq_busy, go IDLE; this has priority over every other transition.
REQ-024 Re-assertion of seq_en after abort SHALL restart from stage 0 with full DLY_CYC delay.
REQ-025 With immediate acks, seq_done SHALL rise NUM_STG*(DLY_CYC+1) cycles after the sampling edge of seq_en.

Reset
REQ-026 rst=1 SHALL, at the next rising edge, force IDLE, idx=0, cnt=0, rst_out_n=all 0, seq_busy=0, seq_done=0, seq_err=0, overriding seq_en.
REQ-027 rst asserted mid-sequence SHALL behave identically to REQ-026; no stage remains released.

Verification
REQ-028 Defaults, stat_n=4'b0000 held, seq_en 0->1 at edge E0 -> rst_out_n = 0001 @E0+8, 0011 @E0+17, 0111 @E0+26, 1111 @E0+35, seq_done=1 @E0+36.
REQ-029 Defaults, stat_n[1] stuck 1 -> rst_out_n=0011 after E0+17, seq_err=1 and rst_out_n=0000 after edge E0+17+255; seq_en=0 -> IDLE, seq_err=0 next edge.
REQ-030 stat_n[1] falls on exactly the 255th ACK sample -> advances to stage 2, seq_err stays 0.
REQ-031 In DONE, drive stat_n[2]=1 -> seq_err=1, seq_done=0, rst_out_n=0000 next edge.
REQ-032 seq_en drops on the same edge stat_n[idx] falls in ACK -> IDLE, rst_out_n=0000, no advance; re-raise -> rst_out_n[0] rises 8 cycles later.
REQ-033 rst=1 for one cycle during DLY of stage 2 with seq_en=1 -> all outputs 0 next edge; after rst low, sequence restarts from stage 0.
